// File: rtl/mlp_layer_sequencer_if.sv
// MAC start/done handshake bundle between the layer sequencer (master)
// and the mac datapath (slave).
interface mlp_layer_sequencer_if #(
  parameter int unsigned NUM_FEATURES  = 4,
  parameter int unsigned FP_TOTAL_BITS = 16
);
  logic                                         mac_start;
  logic signed [NUM_FEATURES*FP_TOTAL_BITS-1:0] mac_x;
  logic signed [NUM_FEATURES*FP_TOTAL_BITS-1:0] mac_weights;
  logic signed [FP_TOTAL_BITS-1:0]              mac_bias;
  logic signed [FP_TOTAL_BITS-1:0]              mac_output;
  logic                                         mac_done;

  modport master (
    output mac_start, mac_x, mac_weights, mac_bias,
    input  mac_output, mac_done
  );

  modport slave (
    input  mac_start, mac_x, mac_weights, mac_bias,
    output mac_output, mac_done
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Fully connected layer sequencer: latches a feature vector, fetches each
// neuron's weights/bias from a synchronous memory, runs one MAC per neuron
// and streams the per-neuron results out.
// Optional build macro: MLP_SEQ_RELU_EN clamps negative results to zero.
module mlp_layer_sequencer #(
  parameter int unsigned NUM_FEATURES  = 4,
  parameter int unsigned NUM_NEURONS   = 8,
  parameter int unsigned FP_TOTAL_BITS = 16,
  parameter int unsigned FP_FRAC_BITS  = 8,
  parameter int unsigned MAC_TIMEOUT   = 15
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              layer_start,
  input  logic signed [NUM_FEATURES*FP_TOTAL_BITS-1:0]      x_in,
  output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] w_addr,
  output logic                                              w_rd_en,
  input  logic signed [NUM_FEATURES*FP_TOTAL_BITS-1:0]      w_rdata,
  input  logic signed [FP_TOTAL_BITS-1:0]                   b_rdata,
  mlp_layer_sequencer_if.master                             mac,
  output logic                                              y_valid,
  output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] y_index,
  output logic signed [FP_TOTAL_BITS-1:0]                   y_data,
  output logic                                              layer_busy,
  output logic                                              layer_done,
  output logic                                              mac_error
);

  localparam int unsigned AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned TW = $clog2(MAC_TIMEOUT);
  localparam logic [AW-1:0] N_LAST = AW'(NUM_NEURONS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(MAC_TIMEOUT - 1);

  if (NUM_NEURONS < 1) begin : g_bad_neurons
    $error("NUM_NEURONS must be at least 1");
  end
  if (MAC_TIMEOUT < 5) begin : g_bad_timeout
    $error("MAC_TIMEOUT must be at least 5");
  end
  if (FP_FRAC_BITS >= FP_TOTAL_BITS) begin : g_bad_frac
    $error("FP_FRAC_BITS must be smaller than FP_TOTAL_BITS");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t state, state_nx;
  logic   timeout_hit;

  logic signed [NUM_FEATURES*FP_TOTAL_BITS-1:0] x_r;
  logic signed [NUM_FEATURES*FP_TOTAL_BITS-1:0] w_r;
  logic signed [FP_TOTAL_BITS-1:0]              b_r;
  logic [AW-1:0]                                n;
  logic [TW-1:0]                                tcnt;
  logic signed [FP_TOTAL_BITS-1:0]              y_next;
  logic                                         mac_start_r;

`ifdef MLP_SEQ_RELU_EN
  assign y_next = mac.mac_output[FP_TOTAL_BITS-1] ? '0 : mac.mac_output;
`else
  assign y_next = mac.mac_output;
`endif

  assign mac.mac_start   = mac_start_r;
  assign mac.mac_x       = x_r;
  assign mac.mac_weights = w_r;
  assign mac.mac_bias    = b_r;
  assign w_addr          = n;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; done is checked before the timeout so it wins a tie
  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    unique case (state)
      S_IDLE:  if (layer_start) state_nx = S_FETCH;
      S_FETCH: state_nx = S_LOAD;
      S_LOAD:  state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (mac.mac_done) begin
          state_nx = S_WRITE;
        end else if (tcnt == T_LAST) begin
          state_nx    = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_WRITE: state_nx = (n == N_LAST) ? S_DONE : S_FETCH;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand, neuron counter, timeout counter and result capture registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_r    <= '0;
      w_r    <= '0;
      b_r    <= '0;
      n      <= '0;
      tcnt   <= '0;
      y_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (layer_start) begin
            x_r <= x_in;
            n   <= '0;
          end
        end
        S_LOAD: begin
          w_r <= w_rdata;
          b_r <= b_rdata;
        end
        S_START: tcnt <= '0;
        S_WAIT: begin
          if (mac.mac_done) y_data <= y_next;
          else              tcnt   <= tcnt + TW'(1);
        end
        S_WRITE: if (n != N_LAST) n <= n + AW'(1);
        default: ;
      endcase
    end
  end

  // Control outputs registered from the next state so each is a clean
  // flop output that is high exactly while the FSM sits in the matching state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_rd_en     <= 1'b0;
      mac_start_r <= 1'b0;
      y_valid     <= 1'b0;
      y_index     <= '0;
      layer_busy  <= 1'b0;
      layer_done  <= 1'b0;
      mac_error   <= 1'b0;
    end else begin
      w_rd_en     <= (state_nx == S_FETCH);
      mac_start_r <= (state_nx == S_START);
      y_valid     <= (state_nx == S_WRITE);
      layer_busy  <= (state_nx != S_IDLE);
      layer_done  <= (state_nx == S_DONE);
      mac_error   <= timeout_hit;
      if (state_nx == S_WRITE) y_index <= n;
    end
  end

endmodule

// File: doc/mlp_layer_sequencer.md
# mlp_layer_sequencer

Initiator side of the MAC start/done protocol: drives one `mac` instance through every neuron of a fully connected layer. Latches an input feature vector, fetches each neuron's weights and bias from a synchronous weight ROM/RAM, and issues one MAC operation per neuron. Captures each result, optionally applies ReLU, and streams per-neuron outputs to the next layer's buffer. Sits between the layer input buffer, the weight memory and the `mac` datapath.

## Interface
- `NUM_FEATURES`, 4: inputs per neuron; MAC vector length.
- `NUM_NEURONS`, 8: neurons in the layer; must be ≥1.
- `FP_TOTAL_BITS`, 16: fixed-point word width, Q7.8.
- `FP_FRAC_BITS`, 8: fraction bits.
- `MAC_TIMEOUT`, 15: maximum cycles spent in WAIT before abort; must be ≥5.
- `clk`  in  1  clock; all logic rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `layer_start`  in  1  begin layer; sampled only in IDLE.
- `x_in`  in  NUM_FEATURES×FP_TOTAL_BITS signed  feature vector; latched on accepted `layer_start`.
- `w_addr`  out  max(1,$clog2(NUM_NEURONS))  neuron index to weight memory.
- `w_rd_en`  out  1  weight memory read strobe.
- `w_rdata`  in  NUM_FEATURES×FP_TOTAL_BITS signed  weights; valid the cycle after `w_rd_en`.
- `b_rdata`  in  FP_TOTAL_BITS signed  bias; same timing as `w_rdata`.
- `mac_start`  out  1  one-cycle start pulse to MAC.
- `mac_x`, `mac_weights`  out  NUM_FEATURES×FP_TOTAL_BITS signed  MAC operands.
- `mac_bias`  out  FP_TOTAL_BITS signed  MAC bias.
- `mac_output`  in  FP_TOTAL_BITS signed  MAC result; valid only while `mac_done`=1.
- `mac_done`  in  1  MAC completion pulse.
- `y_valid`  out  1  one-cycle pulse: `y_index`/`y_data` valid.
- `y_index`  out  same as `w_addr`  neuron number of result.
- `y_data`  out  FP_TOTAL_BITS signed  neuron result.
- `layer_busy`  out  1  high in every state except IDLE.
- `layer_done`  out  1  one-cycle pulse after last neuron written.
- `mac_error`  out  1  one-cycle pulse on MAC timeout.

## Operation
- FSM states: IDLE, FETCH, LOAD, START, WAIT, WRITE, DONE.
- IDLE: on `layer_start`=1 latch `x_in` into `x_r`, clear neuron counter `n` → FETCH.
- FETCH: `w_rd_en`=1, `w_addr`=n → LOAD.
- LOAD: register `w_rdata` into `w_r`, `b_rdata` into `b_r` → START.
- START: `mac_start`=1 for exactly this cycle; clear timeout counter → WAIT.
- WAIT: on `mac_done`=1, capture `mac_output` → WRITE. Otherwise increment timeout counter; at MAC_TIMEOUT → IDLE with `mac_error` pulse and no `layer_done`.
- WRITE: `y_valid`=1, `y_index`=n, `y_data`=captured value. If n==NUM_NEURONS-1 → DONE, else n+1 → FETCH.
- DONE: `layer_done`=1 → IDLE.
- `mac_x`=`x_r`, `mac_weights`=`w_r`, `mac_bias`=`b_r`, held stable from START until the next LOAD. The MAC samples operands one cycle after start.
- No arithmetic beyond optional ReLU; `y_data` width equals MAC output width, no rescaling.
- `layer_start` while busy: ignored, `x_r` unchanged.
- `mac_done` outside WAIT: ignored.
- `mac_done` on the same cycle the timeout count is reached: done wins, result written.
- NUM_NEURONS=1: single pass FETCH…WRITE → DONE.

## Timing
- Reset (async assert, sync deassert): state IDLE, `n`=0, all registers 0, every output 0.
- Reset mid-layer aborts immediately; no `layer_done`/`mac_error`; partial results are not replayed.
- With a compliant `mac` (done 4 cycles after start pulse), per-neuron period is 8 cycles. Cycle numbering: `layer_start` accepted in cycle 0.
- Cycle schedule:
  - FETCH in cycle 8n+1.
  - `mac_start` in cycle 8n+3.
  - `mac_done` in cycle 8n+7.
  - `y_valid` in cycle 8n+8.
  - `layer_done` in cycle 8·NUM_NEURONS+1.
- `layer_busy` is high in cycles 1 … 8·NUM_NEURONS+1. A new `layer_start` is accepted from cycle 8·NUM_NEURONS+2.
- Outputs `y_*` are registered. Outputs `mac_start`, `w_rd_en`, `layer_done`, `mac_error` are registered state decodes (no combinational path from inputs).

## Configuration
- `MLP_SEQ_RELU_EN` defined: `y_data` = (captured < 0) ? 0 : captured.
- `MLP_SEQ_RELU_EN` undefined: `y_data` = captured `mac_output` unchanged, negatives passed.
- Timing identical in both builds.

## Test plan
- Full layer: NUM_NEURONS=2, `x_in`={0x0100,0x0200,0xFF00,0x0080}. Neuron0 weights all 0x0100, bias 0x0080. Neuron1 weights all 0xFF00, bias 0x0000. Required: `y_valid` cycles 8 and 16; `y_data` 0x0300 then 0xFD80; `layer_done` cycle 17.
- Same stimulus with `MLP_SEQ_RELU_EN`: neuron1 `y_data`=0x0000; neuron0 still 0x0300.
- `x_in` changed and `layer_start` pulsed at cycle 5. Required: ignored; results identical to first test.
- MAC stub never asserts `mac_done`. Required: `mac_error` in cycle 3+MAC_TIMEOUT+1; then IDLE, `layer_busy`=0, no `y_valid`/`layer_done`.
- `reset_n` low at cycle 10, released at 12. Required: all outputs 0 immediately; next `layer_start` restarts at neuron 0 with correct results.
- Stray `mac_done` during FETCH/LOAD. Required: no extra `y_valid`; sequence and values unchanged.
